div_unit: RTL

- Multi-cycle radix-2 restoring divider for the execute stage. Serves DIV/DIVU.
- Consumes the execute-stage ALU control decoded by the pipeline controller into `start` and `signed_div`, plus the forwarded rs/rt operands.
- Drives `stall_div` to the hazard unit, holding the E stage while it runs.
- Delivers quotient/remainder to the HI/LO write path, qualified by the E/M `hilowrite` signal.

---
 rtl/div_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the execute stage (DIV/DIVU).
// Stalls the pipeline while iterating; ready pulses for one cycle with HI/LO results.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] opdata1,
    input  logic [WIDTH-1:0] opdata2,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             ready,
    output logic             stall_div
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;
    logic             r_sign1;
    logic             r_sign2;
    logic             r_signed;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_ready;

    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_quot_final;
    logic [WIDTH-1:0] w_rem_final;

    assign w_abs1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign w_abs2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    // A set shifted-out MSB means the partial remainder already exceeds any divisor,
    // so the trial subtract only has to decide the case where that bit is clear.
    assign w_shift     = {r_rem, r_quot[WIDTH-1]};
    assign w_sub       = {1'b0, w_shift[WIDTH-1:0]} - {1'b0, r_divisor};
    assign w_ge        = w_shift[WIDTH] | ~w_sub[WIDTH];
    assign w_rem_next  = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};

    assign w_quot_final = (r_signed && (r_sign1 ^ r_sign2)) ? -w_quot_next : w_quot_next;
    assign w_rem_final  = (r_signed && r_sign1) ? -w_rem_next : w_rem_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !annul) begin
                        if (opdata2 == '0) begin
                            // Raw dividend parks in the quotient register until it becomes HI.
                            r_quot  <= opdata1;
                            r_state <= S_DIVZERO;
                        end else begin
                            r_rem     <= '0;
                            r_quot    <= w_abs1;
                            r_divisor <= w_abs2;
                            r_sign1   <= opdata1[WIDTH-1];
                            r_sign2   <= opdata2[WIDTH-1];
                            r_signed  <= signed_div;
                            r_cnt     <= '0;
                            r_state   <= S_ON;
                        end
                    end
                end
                S_DIVZERO: begin
                    if (annul) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_lo    <= '1;
                        r_hi    <= r_quot;
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_ON: begin
                    if (annul) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ITER) begin
                            r_lo    <= w_quot_final;
                            r_hi    <= w_rem_final;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result_hi = r_hi;
    assign result_lo = r_lo;
    assign ready     = r_ready;
    assign stall_div = rst && ((r_state == S_IDLE && start && !annul) ||
                               r_state == S_ON || r_state == S_DIVZERO);

endmodule
